// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle 32-bit signed/unsigned radix-2 restoring divider
// for the EX stage. It holds the pipeline through stallreq_for_ex while a
// divide is in flight. Results are held until EX is released by the stall bus.
// Quotient goes to LO and remainder goes to HI.
//
// Optional build macro: DIV_FAST_ZERO_EN. When it is defined, a divide whose
// dividend magnitude is below the divisor magnitude completes straight from
// IDLE with quotient=0 and remainder=dividend.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no divide in flight; outputs hold the last result, valid low
// BUSY  | one shift-subtract step per cycle, MSB first, WIDTH steps
// DZERO | divisor was zero; this cycle produces the fixed divide-by-zero result
// DONE  | result valid; held here while EX is stalled (stall[3])

module ex_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    input  logic             div_req,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stallreq_for_ex,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DZERO = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvsr_r;
    logic             q_neg_r;
    logic             r_neg_r;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             step_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_step;
    logic             fast_hit;
    logic             unused_stall;

    // Only the EX bit of the stall bus matters to this unit.
    assign unused_stall = ^{stall[5:4], stall[2:0]};

    assign stallreq_for_ex = div_req && (state != S_DONE);

    // Operand magnitudes. In unsigned mode the operands are used as they are.
    assign dvd_neg = div_signed & dividend[WIDTH-1];
    assign dvs_neg = div_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    assign dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;

`ifdef DIV_FAST_ZERO_EN
    assign fast_hit = (dvd_mag < dvs_mag);
`else
    assign fast_hit = 1'b0;
`endif

    // One restoring step. The partial remainder stays below the divisor, so
    // WIDTH bits are enough to hold it between steps.
    assign partial   = {rem_r, quo_r[WIDTH-1]};
    assign diff      = partial - {1'b0, dvsr_r};
    assign step_ok   = ~diff[WIDTH];
    assign rem_next  = step_ok ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    assign quo_next  = {quo_r[WIDTH-2:0], step_ok};
    assign last_step = (cnt_r == CNT_W'(WIDTH - 1));

    // Divider FSM, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt_r        <= '0;
            rem_r        <= '0;
            quo_r        <= '0;
            dvsr_r       <= '0;
            q_neg_r      <= 1'b0;
            r_neg_r      <= 1'b0;
            result_valid <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    result_valid <= 1'b0;
                    if (div_req) begin
                        if (divisor == '0) begin
                            // The raw dividend is parked here for the DZERO result.
                            quo_r <= dividend;
                            state <= S_DZERO;
                        end else if (fast_hit) begin
                            quotient     <= '0;
                            remainder    <= dividend;
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            rem_r   <= '0;
                            quo_r   <= dvd_mag;
                            dvsr_r  <= dvs_mag;
                            q_neg_r <= dvd_neg ^ dvs_neg;
                            r_neg_r <= dvd_neg;
                            cnt_r   <= '0;
                            state   <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (!div_req) begin
                        state <= S_IDLE;
                    end else begin
                        rem_r <= rem_next;
                        quo_r <= quo_next;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (last_step) begin
                            quotient     <= q_neg_r ? (~quo_next + 1'b1) : quo_next;
                            remainder    <= r_neg_r ? (~rem_next + 1'b1) : rem_next;
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                        end
                    end
                end
                S_DZERO: begin
                    if (!div_req) begin
                        state <= S_IDLE;
                    end else begin
                        quotient     <= '1;
                        remainder    <= quo_r;
                        result_valid <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!stall[3]) begin
                        result_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
